// File: rtl/urv_dm_wb_bridge_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | urv_dm_wb_bridge_pkg : shared state encodings and constants, rev 1.0       |
// +----------------------------------------------------------------------------+
package urv_dm_wb_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } dm_state_e;

  localparam logic [31:0] C_ERR_DATA = 32'hFFFF_FFFF;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage
`default_nettype wire

// File: rtl/urv_dm_timeout.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | urv_dm_timeout : bus-cycle watchdog with clear/enable, rev 1.0             |
// +----------------------------------------------------------------------------+
module urv_dm_timeout #(
  parameter int unsigned g_limit = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam logic [31:0] C_LAST = 32'(g_limit - 1);

  logic [31:0] cnt_q;
  logic [31:0] cnt_d;

  // Expiry is flagged during the g_limit-th enabled cycle so the abort edge
  // lands exactly g_limit cycles after counting starts.
  assign expired_o = (g_limit != 0) && enable_i && (cnt_q == C_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && !expired_o) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/urv_dm_wb_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | urv_dm_wb_bridge : uRV data-memory port to Wishbone B4 pipelined, rev 1.0  |
// +----------------------------------------------------------------------------+
module urv_dm_wb_bridge
  import urv_dm_wb_bridge_pkg::*;
#(
  parameter int unsigned g_timeout  = 255,
  parameter logic [31:0] g_err_data = C_ERR_DATA
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_data_s_i,
  input  logic [3:0]  dm_data_select_i,
  input  logic        dm_load_i,
  input  logic        dm_store_i,
  output logic [31:0] dm_data_l_o,
  output logic        dm_load_done_o,
  output logic        dm_store_done_o,
  output logic        dm_bus_err_o,
  output logic        dm_busy_o,
  output logic        dm_overrun_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic        wb_stall_i
);

  dm_state_e   state_q, state_d;
  logic [31:0] adr_q, adr_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] dat_q, dat_d;
  logic        we_q, we_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        overrun_q, overrun_d;

  logic req;
  logic busy;
  logic accept;
  logic resp_ok;
  logic expired;

  assign req     = dm_load_i | dm_store_i;
  assign busy    = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
  assign accept  = req && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  // A response only counts once the strobe has actually been taken by the slave.
  assign resp_ok = (state_q == ST_WAIT) || ((state_q == ST_ISSUE) && !wb_stall_i);

  urv_dm_timeout #(
    .g_limit (g_timeout)
  ) u_timeout (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   (accept),
    .enable_i  (busy),
    .expired_o (expired)
  );

  always_comb begin
    state_d   = state_q;
    adr_d     = adr_q;
    sel_d     = sel_q;
    dat_d     = dat_q;
    we_d      = we_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    overrun_d = overrun_q;

    if (accept) begin
      adr_d   = word_align(dm_addr_i);
      sel_d   = dm_data_select_i;
      dat_d   = dm_data_s_i;
      we_d    = !dm_load_i;
      rdata_d = '0;
      err_d   = 1'b0;
    end

    if ((busy && req) || (dm_load_i && dm_store_i)) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_ISSUE;
      end
      ST_ISSUE, ST_WAIT: begin
        if (resp_ok && wb_err_i) begin
          state_d = ST_DONE;
          rdata_d = g_err_data;
          err_d   = 1'b1;
        end else if (resp_ok && wb_ack_i) begin
          state_d = ST_DONE;
          rdata_d = wb_dat_i;
        end else if (expired) begin
          state_d = ST_DONE;
          rdata_d = g_err_data;
          err_d   = 1'b1;
        end else if (state_q == ST_ISSUE && !wb_stall_i) begin
          state_d = ST_WAIT;
        end
      end
      ST_DONE: begin
        state_d = accept ? ST_ISSUE : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      adr_q     <= '0;
      sel_q     <= '0;
      dat_q     <= '0;
      we_q      <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      adr_q     <= adr_d;
      sel_q     <= sel_d;
      dat_q     <= dat_d;
      we_q      <= we_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      overrun_q <= overrun_d;
    end
  end

  assign wb_cyc_o        = busy;
  assign wb_stb_o        = (state_q == ST_ISSUE);
  assign wb_we_o         = we_q;
  assign wb_adr_o        = adr_q;
  assign wb_sel_o        = sel_q;
  assign wb_dat_o        = dat_q;
  assign dm_busy_o       = busy;
  assign dm_overrun_o    = overrun_q;
  assign dm_load_done_o  = (state_q == ST_DONE) && !we_q;
  assign dm_store_done_o = (state_q == ST_DONE) && we_q;
  assign dm_bus_err_o    = (state_q == ST_DONE) && err_q;
  assign dm_data_l_o     = ((state_q == ST_DONE) && !we_q) ? rdata_q : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_urv_dm_wb_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_urv_dm_wb_bridge : directed vector bench for urv_dm_wb_bridge, rev 1.0  |
// +----------------------------------------------------------------------------+
module tb_urv_dm_wb_bridge;

  localparam int TO = 8;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] dm_addr_i;
  logic [31:0] dm_data_s_i;
  logic [3:0]  dm_data_select_i;
  logic        dm_load_i;
  logic        dm_store_i;
  logic [31:0] dm_data_l_o;
  logic        dm_load_done_o;
  logic        dm_store_done_o;
  logic        dm_bus_err_o;
  logic        dm_busy_o;
  logic        dm_overrun_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [31:0] wb_adr_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        wb_err_i;
  logic        wb_stall_i;

  int checks = 0;
  int failures = 0;

  urv_dm_wb_bridge #(
    .g_timeout  (TO),
    .g_err_data (32'hFFFF_FFFF)
  ) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .dm_addr_i        (dm_addr_i),
    .dm_data_s_i      (dm_data_s_i),
    .dm_data_select_i (dm_data_select_i),
    .dm_load_i        (dm_load_i),
    .dm_store_i       (dm_store_i),
    .dm_data_l_o      (dm_data_l_o),
    .dm_load_done_o   (dm_load_done_o),
    .dm_store_done_o  (dm_store_done_o),
    .dm_bus_err_o     (dm_bus_err_o),
    .dm_busy_o        (dm_busy_o),
    .dm_overrun_o     (dm_overrun_o),
    .wb_cyc_o         (wb_cyc_o),
    .wb_stb_o         (wb_stb_o),
    .wb_we_o          (wb_we_o),
    .wb_adr_o         (wb_adr_o),
    .wb_sel_o         (wb_sel_o),
    .wb_dat_o         (wb_dat_o),
    .wb_dat_i         (wb_dat_i),
    .wb_ack_i         (wb_ack_i),
    .wb_err_i         (wb_err_i),
    .wb_stall_i       (wb_stall_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit          load;
    bit          store;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    logic [31:0] rdata;
    int          stall;
    int          dly;
    bit          err;
    logic [31:0] exp_adr;
    logic [31:0] exp_data;
    bit          exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[9];

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b expected=%b", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    dm_load_i  = 1'b0;
    dm_store_i = 1'b0;
    wb_ack_i   = 1'b0;
    wb_err_i   = 1'b0;
    wb_stall_i = 1'b0;
    wb_dat_i   = 32'h0BAD_0BAD;
  endtask

  // Count done pulses over n cycles with the slave quiet.
  task automatic count_dones(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (dm_load_done_o || dm_store_done_o) cnt++;
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    bit seen;
    int done_k;
    int k;
    string nm;
    nm = $sformatf("v%0d", idx);
    dm_addr_i        = v.addr;
    dm_data_s_i      = v.wdata;
    dm_data_select_i = v.sel;
    dm_load_i        = v.load;
    dm_store_i       = v.store;
    step();
    dm_load_i  = 1'b0;
    dm_store_i = 1'b0;
    seen   = 1'b0;
    done_k = 0;
    k      = 1;
    while (!seen && k <= 30) begin
      if (k == 1) begin
        chk1({nm, "_cyc"}, wb_cyc_o, 1'b1);
        chk1({nm, "_stb"}, wb_stb_o, 1'b1);
        chk1({nm, "_we"}, wb_we_o, v.store & ~v.load);
        chk({nm, "_adr"}, wb_adr_o, v.exp_adr);
        chk({nm, "_sel"}, {28'h0, wb_sel_o}, {28'h0, v.sel});
        chk({nm, "_dat"}, wb_dat_o, v.wdata);
      end else if (k <= v.stall + 1 && k <= TO) begin
        chk1($sformatf("%s_stb_hold%0d", nm, k), wb_stb_o, 1'b1);
        chk($sformatf("%s_adr_hold%0d", nm, k), wb_adr_o, v.exp_adr);
      end
      wb_stall_i = (k <= v.stall);
      wb_ack_i   = (k == v.stall + 1 + v.dly);
      wb_err_i   = (k == v.stall + 1 + v.dly) && v.err;
      wb_dat_i   = (k == v.stall + 1 + v.dly) ? v.rdata : 32'h0BAD_0BAD;
      step();
      idle_inputs();
      k++;
      if (dm_load_done_o || dm_store_done_o) begin
        seen   = 1'b1;
        done_k = k;
        chk1({nm, "_load_done"}, dm_load_done_o, v.load);
        chk1({nm, "_store_done"}, dm_store_done_o, v.store & ~v.load);
        chk1({nm, "_bus_err"}, dm_bus_err_o, v.exp_err);
        chk({nm, "_data_l"}, dm_data_l_o, v.exp_data);
        chk1({nm, "_cyc_done"}, wb_cyc_o, 1'b0);
      end
    end
    chk1({nm, "_done_seen"}, seen, 1'b1);
    chk({nm, "_latency"}, done_k, v.exp_lat);
    step();
    chk1({nm, "_single_done"}, dm_load_done_o | dm_store_done_o, 1'b0);
    chk1({nm, "_idle_busy"}, dm_busy_o, 1'b0);
    chk({nm, "_idle_data"}, dm_data_l_o, 32'h0);
  endtask

  initial begin
    int cnt;
    bit seen;

    // load, store, addr, wdata, sel, rdata, stall, dly, err, exp_adr, exp_data, exp_err, exp_lat
    vecs[0] = '{1'b1, 1'b0, 32'h0000_1006, 32'h0, 4'b0011, 32'h1234_5678, 0, 1, 1'b0,
                32'h0000_1004, 32'h1234_5678, 1'b0, 3};
    vecs[1] = '{1'b0, 1'b1, 32'h0000_2000, 32'hAABB_CCDD, 4'b1111, 32'h5555_5555, 4, 1, 1'b0,
                32'h0000_2000, 32'h0, 1'b0, 7};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_3008, 32'h0, 4'b1111, 32'h1357_9BDF, 0, 1, 1'b1,
                32'h0000_3008, 32'hFFFF_FFFF, 1'b1, 3};
    vecs[3] = '{1'b1, 1'b0, 32'h0000_4003, 32'h0, 4'b1000, 32'hCAFE_F00D, 0, 0, 1'b0,
                32'h0000_4000, 32'hCAFE_F00D, 1'b0, 2};
    vecs[4] = '{1'b1, 1'b0, 32'h0000_5000, 32'h0, 4'b1111, 32'h2222_2222, 0, 100, 1'b0,
                32'h0000_5000, 32'hFFFF_FFFF, 1'b1, 9};
    vecs[5] = '{1'b0, 1'b1, 32'h0000_6001, 32'h0102_0304, 4'b0010, 32'h3333_3333, 2, 1, 1'b1,
                32'h0000_6000, 32'h0, 1'b1, 5};
    vecs[6] = '{1'b0, 1'b1, 32'h0000_600A, 32'h1122_3344, 4'b0100, 32'h4444_4444, 0, 3, 1'b0,
                32'h0000_6008, 32'h0, 1'b0, 5};
    vecs[7] = '{1'b1, 1'b0, 32'h0000_7FFC, 32'h0, 4'b1111, 32'h6666_6666, 20, 1, 1'b0,
                32'h0000_7FFC, 32'hFFFF_FFFF, 1'b1, 9};
    vecs[8] = '{1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0, 4'b0001, 32'h8765_4321, 1, 0, 1'b0,
                32'hFFFF_FFFC, 32'h8765_4321, 1'b0, 3};

    idle_inputs();
    dm_addr_i        = 32'hFFFF_FFFF;
    dm_data_s_i      = 32'hFFFF_FFFF;
    dm_data_select_i = 4'hF;
    rst_i            = 1'b1;
    step();
    step();
    chk1("rst_cyc", wb_cyc_o, 1'b0);
    chk1("rst_stb", wb_stb_o, 1'b0);
    chk1("rst_done", dm_load_done_o | dm_store_done_o | dm_bus_err_o, 1'b0);
    chk1("rst_busy", dm_busy_o, 1'b0);
    chk1("rst_overrun", dm_overrun_o, 1'b0);
    chk("rst_adr", wb_adr_o, 32'h0);
    chk("rst_data_l", dm_data_l_o, 32'h0);
    rst_i = 1'b0;
    step();

    for (int i = 0; i < 9; i++) begin
      run_vec(vecs[i], i);
    end
    chk1("no_overrun_after_table", dm_overrun_o, 1'b0);

    // Stray responses in IDLE.
    wb_ack_i = 1'b1;
    wb_err_i = 1'b1;
    step();
    idle_inputs();
    chk1("stray_cyc", wb_cyc_o, 1'b0);
    count_dones(3, cnt);
    chk("stray_dones", cnt, 0);

    // Timeout followed by a late ack two cycles after the done pulse.
    dm_addr_i = 32'h0000_7000;
    dm_load_i = 1'b1;
    step();
    dm_load_i = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      if (dm_load_done_o) seen = 1'b1;
    end
    chk1("late_to_done", seen, 1'b1);
    chk1("late_to_err", dm_bus_err_o, 1'b1);
    step();
    step();
    wb_ack_i = 1'b1;
    wb_dat_i = 32'h7777_7777;
    step();
    idle_inputs();
    chk1("late_ack_no_done", dm_load_done_o | dm_store_done_o, 1'b0);
    count_dones(3, cnt);
    chk("late_ack_dones", cnt, 0);
    chk1("late_ack_busy", dm_busy_o, 1'b0);

    // Second load arriving in WAIT is dropped and flagged.
    dm_addr_i        = 32'h0000_8004;
    dm_data_select_i = 4'hF;
    dm_load_i        = 1'b1;
    step();
    dm_load_i = 1'b0;
    step();
    dm_addr_i = 32'h0000_9000;
    dm_load_i = 1'b1;
    step();
    dm_load_i = 1'b0;
    chk1("ovr_flag", dm_overrun_o, 1'b1);
    chk("ovr_adr_kept", wb_adr_o, 32'h0000_8004);
    chk1("ovr_busy", dm_busy_o, 1'b1);
    wb_ack_i = 1'b1;
    wb_dat_i = 32'h55AA_55AA;
    step();
    idle_inputs();
    chk1("ovr_done", dm_load_done_o, 1'b1);
    chk("ovr_data", dm_data_l_o, 32'h55AA_55AA);
    count_dones(5, cnt);
    chk("ovr_extra_dones", cnt, 0);
    chk1("ovr_sticky", dm_overrun_o, 1'b1);

    // New request accepted in the DONE cycle.
    dm_addr_i = 32'h0000_A000;
    dm_load_i = 1'b1;
    step();
    dm_load_i = 1'b0;
    step();
    wb_ack_i = 1'b1;
    wb_dat_i = 32'h0000_0001;
    step();
    idle_inputs();
    chk1("b2b_first_done", dm_load_done_o, 1'b1);
    dm_addr_i        = 32'h0000_B000;
    dm_data_s_i      = 32'hDEAD_BEEF;
    dm_data_select_i = 4'b1100;
    dm_store_i       = 1'b1;
    step();
    dm_store_i = 1'b0;
    chk1("b2b_stb", wb_stb_o, 1'b1);
    chk1("b2b_we", wb_we_o, 1'b1);
    chk("b2b_adr", wb_adr_o, 32'h0000_B000);
    chk("b2b_dat", wb_dat_o, 32'hDEAD_BEEF);
    chk1("b2b_no_done", dm_load_done_o | dm_store_done_o, 1'b0);
    step();
    wb_ack_i = 1'b1;
    step();
    idle_inputs();
    chk1("b2b_store_done", dm_store_done_o, 1'b1);
    chk("b2b_store_data_l", dm_data_l_o, 32'h0);
    step();

    // Reset in WAIT aborts silently.
    dm_addr_i = 32'h0000_C100;
    dm_load_i = 1'b1;
    step();
    dm_load_i = 1'b0;
    step();
    chk1("mid_rst_in_wait", wb_cyc_o & ~wb_stb_o, 1'b1);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    chk1("mid_rst_cyc", wb_cyc_o, 1'b0);
    chk1("mid_rst_stb", wb_stb_o, 1'b0);
    chk1("mid_rst_done", dm_load_done_o | dm_store_done_o, 1'b0);
    chk1("mid_rst_overrun", dm_overrun_o, 1'b0);
    count_dones(4, cnt);
    chk("mid_rst_dones", cnt, 0);
    run_vec(vecs[0], 100);

    // Simultaneous load and store: load wins, overrun set.
    dm_addr_i        = 32'h0000_C00C;
    dm_data_s_i      = 32'h0F0F_0F0F;
    dm_data_select_i = 4'b0001;
    dm_load_i        = 1'b1;
    dm_store_i       = 1'b1;
    step();
    dm_load_i  = 1'b0;
    dm_store_i = 1'b0;
    chk1("coll_stb", wb_stb_o, 1'b1);
    chk1("coll_we", wb_we_o, 1'b0);
    chk1("coll_overrun", dm_overrun_o, 1'b1);
    step();
    wb_ack_i = 1'b1;
    wb_dat_i = 32'h0000_00EE;
    step();
    idle_inputs();
    chk1("coll_load_done", dm_load_done_o, 1'b1);
    chk1("coll_store_done", dm_store_done_o, 1'b0);
    chk("coll_data", dm_data_l_o, 32'h0000_00EE);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/urv_dm_wb_bridge.md
Name: urv_dm_wb_bridge

Overview:
- Responder end of the uRV data-memory request interface.
- Accepts the single-cycle load/store strobes, address, store data and byte select that the execute stage drives.
- Runs each request as one Wishbone B4 pipelined transfer.
- Returns load data and done strobes to the writeback stage. Sits between the CPU core and the system interconnect.

Parameters:
g_timeout, 255, bus cycles (counted while wb_cyc_o=1) before an unanswered transfer is aborted; 0 disables the timeout
g_err_data, 32'hFFFF_FFFF, value returned on dm_data_l_o for an errored or timed-out load

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
dm_addr_i  in  32  byte address, valid with a load or store strobe
dm_data_s_i  in  32  store data, already lane-replicated
dm_data_select_i  in  4  byte enables
dm_load_i  in  1  load request strobe, one cycle
dm_store_i  in  1  store request strobe, one cycle
dm_data_l_o  out  32  load data, valid while dm_load_done_o=1
dm_load_done_o  out  1  one-cycle load completion
dm_store_done_o  out  1  one-cycle store completion
dm_bus_err_o  out  1  one-cycle pulse, coincident with done, on wb_err_i or timeout
dm_busy_o  out  1  transfer in progress
dm_overrun_o  out  1  sticky: request arrived while busy, or load and store asserted together
wb_cyc_o  out  1  Wishbone cycle
wb_stb_o  out  1  Wishbone strobe
wb_we_o  out  1  write enable
wb_adr_o  out  32  address, word-aligned: dm_addr_i[31:2],2'b00
wb_sel_o  out  4  byte select
wb_dat_o  out  32  write data
wb_dat_i  in  32  read data
wb_ack_i  in  1  acknowledge
wb_err_i  in  1  bus error
wb_stall_i  in  1  pipeline stall

Behaviour:
- Clock and reset: one clock, clk_i. rst_i is synchronous and active-high.
- Reset values: all outputs 0, including dm_overrun_o. State returns to IDLE.
- IDLE: on a cycle with dm_load_i or dm_store_i, latch address, select, data and direction.
  - Next edge: state ISSUE, and wb_cyc_o=wb_stb_o=1 with all latched fields driven.
  - Request to strobe latency is one cycle.
- ISSUE: hold stb and all fields while wb_stall_i=1.
  - On the edge where wb_stall_i=0, drop wb_stb_o and go to WAIT. cyc stays 1.
  - If ack or err arrives in the same cycle as the stall-free strobe, go directly to DONE.
- WAIT: hold cyc=1. On the first edge with wb_ack_i or wb_err_i, go to DONE.
  - If both are asserted in the same cycle, err has priority.
  - Latch wb_dat_i on ack; latch g_err_data on err.
  - Drop wb_cyc_o on that same edge.
- DONE (one cycle): assert exactly one of dm_load_done_o or dm_store_done_o. Assert dm_bus_err_o if errored.
  - dm_data_l_o holds the latched value during the done cycle for loads. It is 0 for stores and in all other cycles.
  - Next edge returns to IDLE.
  - A new request presented in the DONE cycle is accepted: DONE behaves as IDLE for acceptance.
  - Minimum per-transfer latency, request to done, with zero stall and ack one cycle after strobe: 3 cycles.
- Timeout: counter clears on request accept and increments each cycle in ISSUE or WAIT.
  - Reaching g_timeout forces DONE with an error, g_err_data returned for loads, and cyc/stb dropped.
  - A late ack after a timeout is ignored.
- dm_busy_o=1 in ISSUE and WAIT.
- Request while busy (ISSUE/WAIT): ignored and sets dm_overrun_o. The in-flight transfer is unaffected.
- dm_load_i and dm_store_i asserted together: the load is served and dm_overrun_o is set.
- Reset mid-transfer: cyc, stb and all done strobes are 0 after the reset edge. No done pulse is produced for the aborted transfer.
- Stray ack or err in IDLE: ignored.

Decomposition:
- Shared definitions, in the existing defines include: state encodings (IDLE, ISSUE, WAIT, DONE) and the default error data constant.
- Natural sub-module: urv_dm_timeout, the cycle counter with clear, enable and expired outputs, reused later for the instruction bus.

Test Plan:
- Load, no stall: dm_load_i with addr 0x0000_1006, select 0011. Slave acks the cycle after stb with data 0x1234_5678 → wb_adr_o=0x0000_1004, wb_we_o=0. dm_load_done_o 3 cycles after the request with dm_data_l_o=0x1234_5678.
- Store with stall: dm_store_i, data 0xAABBCCDD, select 1111. Slave holds wb_stall_i=1 for 4 cycles → stb and fields stable throughout; a single dm_store_done_o. dm_data_l_o stays 0.
- Bus error: load, slave returns wb_err_i=1 → dm_load_done_o with dm_bus_err_o=1 and dm_data_l_o=0xFFFFFFFF.
- Timeout: g_timeout=8, slave silent → done and err pulse exactly 8 cycles after cyc rises. A late ack 2 cycles later produces no extra done.
- Overrun and collision:
  - A second load during WAIT → dm_overrun_o=1, only the first transfer completes.
  - Simultaneous load and store in IDLE → load transfer issued (wb_we_o=0), overrun set.
- Reset mid-transfer: rst_i in WAIT → cyc=0 next cycle, no done pulse. A following load completes normally.
